// File: rtl/program_loader.sv
// program_loader: framed byte-stream loader for the 2048 x 14 program memory.
// Optional trailing checksum byte and CHKSUM/CHECK states: LOADER_CHECKSUM_EN.
module program_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [10:0] Prog_addr_out,
  output logic [13:0] Prog_data_out,
  output logic        Prog_wr_en,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [3:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA_HI,
    DATA_LO,
`ifdef LOADER_CHECKSUM_EN
    CHKSUM,
    CHECK,
`endif
    DONE,
    ERR
  } state_t;

  state_t      state;
  logic [10:0] count;
  logic [5:0]  word_hi;
  logic [7:0]  csum;
  logic        acc;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  rx_sum;
  assign in_ready = (state != CHECK);
`else
  assign in_ready = 1'b1;
`endif

  assign acc = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      word_hi       <= '0;
      csum          <= '0;
      Prog_addr_out <= '0;
      Prog_data_out <= '0;
      Prog_wr_en    <= 1'b0;
      cpu_hold      <= 1'b0;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      rx_sum        <= '0;
`endif
    end else begin
      Prog_wr_en <= 1'b0;
      // Prog_addr_out doubles as the address counter; it steps after the strobe
      if (Prog_wr_en)
        Prog_addr_out <= Prog_addr_out + 11'd1;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (acc && in_byte == 8'hA5) begin
            Prog_addr_out <= '0;
            csum          <= '0;
            load_done     <= 1'b0;
            load_err      <= 1'b0;
            cpu_hold      <= 1'b1;
            state         <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (acc) begin
            csum        <= csum + in_byte;
            count[10:8] <= in_byte[2:0];
            if (in_byte[7:3] != 5'd0) begin
              load_err <= 1'b1;
              state    <= ERR;
            end else begin
              state <= CNT_LO;
            end
          end
        end
        CNT_LO: begin
          if (acc) begin
            csum       <= csum + in_byte;
            count[7:0] <= in_byte;
            state      <= DATA_HI;
          end
        end
        DATA_HI: begin
          if (acc) begin
            csum    <= csum + in_byte;
            word_hi <= in_byte[5:0];
            if (in_byte[7:6] != 2'd0) begin
              load_err <= 1'b1;
              state    <= ERR;
            end else begin
              state <= DATA_LO;
            end
          end
        end
        DATA_LO: begin
          if (acc) begin
            csum          <= csum + in_byte;
            Prog_data_out <= {word_hi, in_byte};
            Prog_wr_en    <= 1'b1;
            if (Prog_addr_out == count) begin
`ifdef LOADER_CHECKSUM_EN
              state <= CHKSUM;
`else
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
              state     <= DONE;
`endif
            end else begin
              state <= DATA_HI;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHKSUM: begin
          if (acc) begin
            rx_sum <= in_byte;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (rx_sum == csum) begin
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
            state     <= DONE;
          end else begin
            load_err <= 1'b1;
            state    <= ERR;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream loader that writes 14-bit instruction words into the 2048 x 14 program memory that the core fetches from over the 11-bit program address bus. It receives framed bytes from the host serial link through a valid/ready handshake, assembles two bytes per instruction, and issues one write strobe per word starting at address 0. While loading, it holds the CPU. It reports completion or a framing/checksum error.

## Interface
- No parameters; widths are fixed: 8-bit bytes, 14-bit words, 11-bit addresses.
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_byte  input  8  incoming byte
- in_valid  input  1  in_byte is valid this cycle
- in_ready  output  1  loader accepts in_byte this cycle
- Prog_addr_out  output  11  program memory write address
- Prog_data_out  output  14  program memory write data
- Prog_wr_en  output  1  one-cycle write strobe
- cpu_hold  output  1  keep core in reset/stall
- load_done  output  1  last load completed successfully (level)
- load_err  output  1  last load aborted (level)

## Operation
- Handshake: a byte is accepted on any rising edge where in_valid && in_ready.
- in_ready is 1 in every state except CHECK.
- States: IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHKSUM, CHECK, DONE, ERR.
- IDLE, DONE, ERR: an accepted 0xA5 sync byte clears the address counter, the checksum, load_done and load_err, sets cpu_hold, and enters CNT_HI. All other bytes are discarded.
- CNT_HI: bits[2:0] are count[10:8]. If bits[7:3] are not 0, enter ERR.
- CNT_LO: the byte is count[7:0]. Count holds N-1, so 1..2048 words are loaded. Next state is DATA_HI.
- DATA_HI: bits[5:0] are word[13:8]. If bits[7:6] are not 0, enter ERR.
- DATA_LO: the byte is word[7:0]. Register the write (see Timing). If the address counter is at N-1, go to CHKSUM (or DONE, see Configuration); otherwise go to DATA_HI.
- A byte value of 0xA5 is ordinary data after sync; there is no mid-frame resync.
- Address counter: 11 bits, increments after each write.
  - With N = 2048, the last write is at 0x7FF and the counter wraps to 0.
  - No word is ever written past N-1.
- Checksum: 8-bit modulo-256 sum of every accepted byte after sync, up to but excluding the checksum byte.
- CHKSUM: accept one byte, then enter CHECK.
- CHECK: lasts one cycle.
  - Match: go to DONE.
  - Mismatch: go to ERR.
- DONE: load_done=1, cpu_hold=0.
- ERR: load_err=1, cpu_hold stays 1 until the next sync byte or reset. Memory may be partially written.

## Timing
- Reset values: state IDLE, in_ready 1, Prog_addr_out 0, Prog_data_out 0, Prog_wr_en 0, cpu_hold 0, load_done 0, load_err 0.
- Write latency:
  - Prog_wr_en pulses high for exactly one cycle, in the cycle after the DATA_LO byte is accepted.
  - Prog_addr_out and Prog_data_out are registered and valid in that same cycle.
  - Address increments at the end of that cycle.
- The next write is at most every 2 cycles, because each word takes two bytes. Back-to-back bytes never collide with a pending write.
- cpu_hold rises the cycle after the sync byte is accepted.
- load_done or load_err rises on the edge that enters DONE or ERR.
- Reset asserted mid-load: all outputs return to reset values immediately, and any write in flight is dropped.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - The frame ends with one checksum byte and the CHKSUM/CHECK states exist.
  - DONE is entered 2 cycles after the checksum byte is accepted.
- LOADER_CHECKSUM_EN undefined:
  - There is no checksum byte, and CHKSUM/CHECK are removed.
  - DATA_LO for the last word goes to DONE on the same edge that registers the last Prog_wr_en.
  - load_done is therefore high in the strobe cycle.
  - in_ready is constant 1.

## Test plan
- Basic load (checksum on):
  - Stimulus: 0xA5, 0x00, 0x01, 0x30, 0x05, 0x00, 0xA5, checksum 0xDB.
  - Required: writes of 0x3005 to address 0 and 0x00A5 to address 1, then load_done=1, cpu_hold=0.
- Bad checksum: the same frame with a final byte of 0x00.
  - Required: both writes still occur, then load_err=1 with cpu_hold still 1.
  - A new sync byte clears load_err.
- Framing errors:
  - CNT_HI byte 0x08 -> ERR with no writes.
  - DATA_HI byte 0x40 -> ERR, and the counter does not advance for that word.
- Full memory: count 0x07FF followed by 2048 words.
  - Required: the last write is at 0x7FF, the counter wraps to 0, and no extra strobe occurs.
- Reset at random points mid-frame:
  - Required: outputs are at reset values on the next cycle.
  - Non-sync bytes in IDLE are ignored.
- Throttled in_valid with random gaps: the write sequence is identical to the gap-free case.
